// File: rtl/spi_mailbox_target_if.sv
// Bus bundle for spi_mailbox_target: the SPI pins toward the external host
// plus the CPU data-bus side (register index, data, strobes, irq, busy).
interface spi_mailbox_target_if #(
  parameter int ADDR_W = 4
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] Addr;
  logic [15:0]       Din;
  logic [15:0]       Dout;
  logic              write;
  logic              CS;
  logic              irq;
  logic              busy;

  // The mailbox block itself.
  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, Addr, Din, write, CS,
    output spi_miso, spi_miso_oe, Dout, irq, busy
  );

  // The surroundings: SPI host plus CPU.
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, Addr, Din, write, CS,
    input  spi_miso, spi_miso_oe, Dout, irq, busy
  );
endinterface

// File: rtl/spi_mailbox_target.sv
// SPI mode-0 target giving an external host read/write access to a bank of
// 16-bit mailbox registers that the CPU also reads and writes. The SPI pins
// are oversampled on clk; all SPI activity is driven by detected sclk edges.
module spi_mailbox_target #(
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  spi_mailbox_target_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic              sclk_prev_q;
  logic              sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [1:0]        fill_q;
  logic              armed_q;
  logic [3:0]        bit_cnt_q;
  logic [14:0]       shift_in_q;
  logic [15:0]       shift_out_q;
  logic              out_active_q;
  logic              wr_frame_q;
  logic [ADDR_W-1:0] idx_q;
  logic [15:0]       regs_q [DEPTH];
  logic              irq_q;
  logic              word_done, spi_wr;
  logic [15:0]       rx_word;

  // Double-flop the asynchronous SPI pins; a third sclk stage gives edges.
  // NOTE: every clocked block uses <= so all flops update from the same
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Arm frame start only after cs is seen high through a refilled
  // synchronizer, so a frame already running at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else if (fill_q != 2'd2) begin
      fill_q <= fill_q + 2'd1;
    end else if (cs_s) begin
      armed_q <= 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next frame state: cs high always forces IDLE.
  // NOTE: state_d gets its default first so no path leaves it unassigned,
  // which is what keeps this block from inferring a latch.
  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (armed_q) state_d = ST_HDR;
        ST_HDR:  if (sclk_rise && bit_cnt_q == 4'd7) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx_word   = {shift_in_q, mosi_s};
  assign word_done = (state_q == ST_DATA) && !cs_s && sclk_rise && (bit_cnt_q == 4'd15);
  assign spi_wr    = word_done && wr_frame_q;

  // Bit counting, header capture, index stepping and the MISO shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= 4'd0;
      shift_in_q   <= '0;
      shift_out_q  <= '0;
      out_active_q <= 1'b0;
      wr_frame_q   <= 1'b0;
      idx_q        <= '0;
    end else if (state_q == ST_IDLE || cs_s) begin
      bit_cnt_q    <= 4'd0;
      shift_out_q  <= '0;
      out_active_q <= 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_in_q <= {shift_in_q[13:0], mosi_s};
        if (state_q == ST_HDR && bit_cnt_q == 4'd7) begin
          wr_frame_q <= shift_in_q[6];
          idx_q      <= {shift_in_q[ADDR_W-2:0], mosi_s};
          bit_cnt_q  <= 4'd0;
        end else if (word_done) begin
          idx_q     <= idx_q + ADDR_W'(1);
          bit_cnt_q <= 4'd0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end
      if (sclk_fall && state_q == ST_DATA && !wr_frame_q) begin
        if (bit_cnt_q == 4'd0) begin
          shift_out_q  <= regs_q[idx_q];
          out_active_q <= 1'b1;
        end else begin
          shift_out_q <= {shift_out_q[14:0], 1'b0};
        end
      end
    end
  end

  // Register bank and irq; the SPI write is placed last so it wins a
  // same-index collision with the CPU, while different indices both land.
  // NOTE: the bank is cleared by reset because a zeroed mailbox is visible
  // behaviour, so it is built from flops rather than a resetless RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 16'h0000;
      irq_q <= 1'b0;
    end else begin
      if (bus.CS && bus.write) regs_q[bus.Addr] <= bus.Din;
      if (spi_wr)              regs_q[idx_q]    <= rx_word;
      irq_q <= spi_wr;
    end
  end

  assign bus.Dout        = bus.CS ? regs_q[bus.Addr] : 16'h0000;
  assign bus.spi_miso    = out_active_q & ~cs_s & shift_out_q[15];
  assign bus.spi_miso_oe = ~cs_s;
  assign bus.busy        = ~cs_s;
  assign bus.irq         = irq_q;
endmodule

// File: doc/spi_mailbox_target.md
# spi_mailbox_target

SPI mode-0 target (responder) giving an external SPI host read/write access to a bank of 16-bit mailbox registers that the CPU also reads and writes through its data bus. It is the far end of the SPI link driven by the IO block's SPI master (MoSi/clkOUT/CSout/MiSo). It sits on the CPU data bus in the same way as the RAM, selected by a chip-select decoded from the upper address bits. Every completed SPI write raises a one-cycle interrupt pulse, which is wired to one of the CPU `Interrupts` lines.

## Interface
- ADDR_W, 4: register index width; the bank holds 2^ADDR_W words of 16 bits.
- clk  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from the host; asynchronous to clk.
- spi_cs_n  in  1  SPI chip select from the host, active low.
- spi_mosi  in  1  host-to-target serial data.
- spi_miso  out  1  target-to-host serial data.
- spi_miso_oe  out  1  MISO output enable; high while a frame is selected.
- Addr  in  ADDR_W  CPU register index.
- Din  in  16  CPU write data.
- Dout  out  16  CPU read data. Combinational: regs[Addr] when CS=1, otherwise 16'h0000.
- write  in  1  CPU write strobe. Takes effect on the clk edge when CS=1.
- CS  in  1  CPU chip select for this block.
- irq  out  1  one-clk pulse after each SPI word written.
- busy  out  1  high while the synchronized spi_cs_n is low.

## Operation
- Input synchronization: spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchronizer. A third flop on sclk provides edge detection: rise = sync & ~prev, fall = ~sync & prev. All SPI logic acts only on these detected edges.
- Frame format, MSB first:
  - Header byte: bit7 = W (1 = write, 0 = read); bits[ADDR_W-1:0] = start index; all other bits are ignored.
  - The header is followed by any number of 16-bit data words.
- States:
  - IDLE: cs high.
  - HDR: count the 8 header bits.
  - DATA: count 16 bits per word.
- Transitions:
  - Synchronized cs falling edge: IDLE -> HDR. The bit counter clears.
  - In HDR, the 8th sclk rise latches the header and goes to DATA.
  - In DATA, each 16th sclk rise completes a word. The state stays in DATA and the index increments modulo 2^ADDR_W (15 wraps to 0).
  - Synchronized cs high in any state: go to IDLE immediately.
- MOSI is sampled on each detected sclk rise.
- Write frames: each completed word is written to regs[index] on the clk cycle after the 16th rise. irq pulses for 1 clk in that same cycle.
- Read frames:
  - On the detected 8th sclk fall (end of the header), load the shift register with regs[index] and drive bit15 on MISO.
  - On each following detected fall, shift left.
  - At the fall following each word's 16th rise, reload from regs[index+1].
  - A read frame never writes any register and never pulses irq.
- MISO is 0 whenever it is not actively shifting data. spi_miso_oe = ~cs_sync.
- Abort: cs rising mid-word discards the partial word. No write, no irq, no index side effects.
- Collision: an SPI write and a CPU write to the same index in the same clk cycle: SPI wins. Writes to different indices both complete.

## Timing
- Reset values: all regs 0; spi_miso 0; spi_miso_oe 0; irq 0; busy 0; state IDLE; counters 0.
- Pin-to-detected-edge latency is 3 clk cycles. Maximum sclk frequency is clk/8; sclk high and low time must each be at least 4 clk cycles.
- MISO is valid no more than 4 clk cycles after each pin-level sclk fall, which is before the next host sample at the minimum half-period.
- The host must hold cs_n low for at least 4 clk cycles before the first sclk rise, and after the last sclk fall.
- The CPU write lands on the clk edge. Dout reflects the new value in the following cycle.
- Asserting rst_n low mid-frame clears everything asynchronously. After release, the block ignores the bus until the next cs falling edge.

## Test plan
- SPI write: header 0x83, data 0xBEEF -> regs[3] = 0xBEEF; CPU read at Addr 3 returns 0xBEEF; exactly one irq pulse.
- SPI read: CPU writes 0x1234 to index 5; SPI header 0x05 followed by 16 clocks -> MISO shifts out 0x1234 MSB first; no irq; regs unchanged.
- Burst wrap: header 0x8F, words 0xAAAA then 0x5555 -> regs[15] = 0xAAAA, regs[0] = 0x5555, two irq pulses.
- Abort: header 0x82, then cs raised after 10 data bits -> regs[2] keeps its old value, no irq, busy drops within 3 cycles.
- Collision: SPI write of 0x0F0F to index 7 completes in the same cycle as a CPU write of 0xF0F0 to index 7 -> regs[7] = 0x0F0F.
- Reset: rst_n pulsed low mid-read -> MISO = 0, oe = 0, all regs 0; the next full frame operates normally.
